// File: rtl/btn_conditioner.sv
// Per-button conditioner: 2-FF synchroniser, debounce, press/release pulses.
// Optional auto-repeat of press pulses while held, enabled by BTN_AUTOREPEAT_EN.
module btn_conditioner #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_BTN-1:0] btn_release
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] syncS1;
  logic [N_BTN-1:0] syncS2;

  always_ff @(posedge CLK) begin
    if (RST) begin
      syncS1 <= '0;
      syncS2 <= '0;
    end else begin
      syncS1 <= btn_raw;
      syncS2 <= syncS1;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HW = (HMAX > 1) ? $clog2(HMAX + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] REPEAT_LAST = HW'(REPEAT_CYCLES - 1);
`else
  // The repeat timing parameters have no effect in this build.
  if (HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : gRepeatParamsIgnored
  end
`endif

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : gBit
      logic          levelBit;
      logic          pulseBit;
      logic          releaseBit;
      logic [CW-1:0] cnt;
      logic          accept;

      assign accept = (syncS2[gi] != levelBit) && (cnt == CNT_LAST);

`ifdef BTN_AUTOREPEAT_EN
      logic [HW-1:0] holdCnt;
      logic          repeating;
`endif

      always_ff @(posedge CLK) begin
        if (RST) begin
          levelBit   <= 1'b0;
          pulseBit   <= 1'b0;
          releaseBit <= 1'b0;
          cnt        <= '0;
`ifdef BTN_AUTOREPEAT_EN
          holdCnt    <= '0;
          repeating  <= 1'b0;
`endif
        end else begin
          pulseBit   <= 1'b0;
          releaseBit <= 1'b0;
          if (syncS2[gi] == levelBit) begin
            cnt <= '0;
          end else if (accept) begin
            levelBit   <= syncS2[gi];
            cnt        <= '0;
            pulseBit   <= syncS2[gi];
            releaseBit <= ~syncS2[gi];
          end else begin
            cnt <= cnt + CW'(1);
          end
`ifdef BTN_AUTOREPEAT_EN
          // holdCnt counts cycles since the last press or repeat pulse.
          if (accept || !levelBit) begin
            holdCnt   <= '0;
            repeating <= 1'b0;
          end else if (holdCnt == (repeating ? REPEAT_LAST : HOLD_LAST)) begin
            pulseBit  <= 1'b1;
            holdCnt   <= '0;
            repeating <= 1'b1;
          end else begin
            holdCnt <= holdCnt + HW'(1);
          end
`endif
        end
      end

      assign btn_level[gi]   = levelBit;
      assign btn_pulse[gi]   = pulseBit;
      assign btn_release[gi] = releaseBit;
    end
  endgenerate

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed table rows plus randomized stimulus
// checked every cycle against a sliding-window reference model.
module tb_btn_conditioner;
  localparam int N = 5;
  localparam int D = 4;
  localparam int H = 10;
  localparam int R = 3;
`ifdef BTN_AUTOREPEAT_EN
  localparam int AR = 1;
`else
  localparam int AR = 0;
`endif

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_level, btn_pulse, btn_release;

  always #5 CLK = ~CLK;

  btn_conditioner #(
    .N_BTN(N), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)
  ) dut (
    .CLK(CLK), .RST(RST), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_pulse(btn_pulse), .btn_release(btn_release)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: raw is seen two edges late; a bit flips once the last
  // D delayed samples all disagree with its level.
  logic [N-1:0] mS1, mS2, mLevel, expP, expR;
  logic [N-1:0] hist[$];
  int           edgeN;
  int           pressEdge[N];

  task automatic modelEdge(input logic rst, input logic [N-1:0] raw);
    logic [N-1:0] used;
    bit allDiff;
    int t;
    expP = '0;
    expR = '0;
    if (rst) begin
      mS1 = '0; mS2 = '0; mLevel = '0;
      hist.delete();
      edgeN = 0;
      for (int b = 0; b < N; b++) pressEdge[b] = 0;
    end else begin
      used = mS2;
      mS2 = mS1;
      mS1 = raw;
      hist.push_back(used);
      if (hist.size() > D) void'(hist.pop_front());
      edgeN++;
      for (int b = 0; b < N; b++) begin
        allDiff = (hist.size() == D);
        for (int i = 0; i < hist.size(); i++)
          if (hist[i][b] == mLevel[b]) allDiff = 0;
        if (allDiff) begin
          mLevel[b] = ~mLevel[b];
          if (mLevel[b]) begin
            expP[b] = 1'b1;
            pressEdge[b] = edgeN;
          end else begin
            expR[b] = 1'b1;
          end
        end else if (AR == 1 && mLevel[b]) begin
          t = edgeN - pressEdge[b];
          if (t == H || (t > H && (t - H) % R == 0)) expP[b] = 1'b1;
        end
      end
    end
  endtask

  int segP, segR;

  task automatic step(input logic rst, input logic [N-1:0] raw);
    RST = rst;
    btn_raw = raw;
    @(posedge CLK);
    modelEdge(rst, raw);
    #1;
    vectors++;
    if ({btn_level, btn_pulse, btn_release} !== {mLevel, expP, expR}) begin
      miscompares++;
      $display("FAIL cycle %0d: level/pulse/release got %b/%b/%b expected %b/%b/%b",
               vectors, btn_level, btn_pulse, btn_release, mLevel, expP, expR);
    end
    segP += $countones(btn_pulse);
    segR += $countones(btn_release);
  endtask

  typedef struct {
    logic         rst;
    logic [N-1:0] raw;
    int           n;
    logic [N-1:0] level;
    int           pulses;
    int           releases;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic [N-1:0] raw, int n,
                              logic [N-1:0] level, int pulses, int releases);
    vec_t v;
    v.rst = rst; v.raw = raw; v.n = n;
    v.level = level; v.pulses = pulses; v.releases = releases;
    return v;
  endfunction

  initial begin
    logic [N-1:0] rnd;
    // reset with all buttons held, then re-debounce after RST falls
    tbl.push_back(mk(1, 5'b11111, 3, 5'b00000, 0, 0));
    tbl.push_back(mk(0, 5'b11111, 5, 5'b00000, 0, 0));
    tbl.push_back(mk(0, 5'b11111, 1, 5'b11111, 5, 0));
    tbl.push_back(mk(0, 5'b11111, 5, 5'b11111, 0, 0));
    tbl.push_back(mk(0, 5'b00000, 10, 5'b00000, 5 * AR, 5));
    // clean press on bit 2
    tbl.push_back(mk(0, 5'b00100, 5, 5'b00000, 0, 0));
    tbl.push_back(mk(0, 5'b00100, 1, 5'b00100, 1, 0));
    tbl.push_back(mk(0, 5'b00100, 14, 5'b00100, 2 * AR, 0));
    tbl.push_back(mk(0, 5'b00000, 10, 5'b00000, 2 * AR, 1));
    // bounce on bit 3, then stable press and release
    tbl.push_back(mk(0, 5'b01000, 1, 5'b00000, 0, 0));
    tbl.push_back(mk(0, 5'b00000, 1, 5'b00000, 0, 0));
    tbl.push_back(mk(0, 5'b01000, 1, 5'b00000, 0, 0));
    tbl.push_back(mk(0, 5'b00000, 1, 5'b00000, 0, 0));
    tbl.push_back(mk(0, 5'b01000, 5, 5'b00000, 0, 0));
    tbl.push_back(mk(0, 5'b01000, 1, 5'b01000, 1, 0));
    tbl.push_back(mk(0, 5'b00000, 5, 5'b01000, 0, 0));
    tbl.push_back(mk(0, 5'b00000, 1, 5'b00000, 0, 1));
    // bits 1 and 4 together, reset lands mid-debounce
    tbl.push_back(mk(0, 5'b10010, 2, 5'b00000, 0, 0));
    tbl.push_back(mk(1, 5'b10010, 1, 5'b00000, 0, 0));
    tbl.push_back(mk(0, 5'b10010, 5, 5'b00000, 0, 0));
    tbl.push_back(mk(0, 5'b10010, 1, 5'b10010, 2, 0));
    tbl.push_back(mk(0, 5'b10010, 30, 5'b10010, 14 * AR, 0));
    tbl.push_back(mk(0, 5'b00000, 10, 5'b00000, 4 * AR, 2));
    // long hold on bit 0
    tbl.push_back(mk(0, 5'b00001, 5, 5'b00000, 0, 0));
    tbl.push_back(mk(0, 5'b00001, 1, 5'b00001, 1, 0));
    tbl.push_back(mk(0, 5'b00001, 30, 5'b00001, 7 * AR, 0));
    tbl.push_back(mk(0, 5'b00000, 10, 5'b00000, 2 * AR, 1));

    for (int r = 0; r < tbl.size(); r++) begin
      segP = 0;
      segR = 0;
      for (int c = 0; c < tbl[r].n; c++) step(tbl[r].rst, tbl[r].raw);
      vectors++;
      if (btn_level !== tbl[r].level || segP != tbl[r].pulses || segR != tbl[r].releases) begin
        miscompares++;
        $display("FAIL row %0d: level/pulses/releases got %b/%0d/%0d expected %b/%0d/%0d",
                 r, btn_level, segP, segR, tbl[r].level, tbl[r].pulses, tbl[r].releases);
      end
    end

    // random bouncy stimulus with occasional resets
    rnd = '0;
    for (int c = 0; c < 800; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) rnd[b] = ~rnd[b];
      step($urandom_range(0, 149) == 0, rnd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
Per-button input conditioner sitting directly upstream of the menu FSM and the task blocks. It takes the raw Basys3 push-buttons (btnC/U/L/R/D) and outputs synchronised, debounced levels plus single-cycle press pulses. The menu samples these pulses every CLK, so one physical press must produce exactly one pulse. All buttons are handled independently and in parallel.

Parameters:
N_BTN, 5, number of buttons; bit order {btnD, btnR, btnL, btnU, btnC} = [4:0].
DEBOUNCE_CYCLES, 500000, cycles the synchronised input must hold a new value before it is accepted (5 ms at 100 MHz); legal range >= 1.
HOLD_CYCLES, 50000000, auto-repeat initial delay (used only with BTN_AUTOREPEAT_EN).
REPEAT_CYCLES, 10000000, auto-repeat period (used only with BTN_AUTOREPEAT_EN).

Ports:
CLK  input  1  system clock, 100 MHz
RST  input  1  synchronous, active-high reset
btn_raw  input  N_BTN  asynchronous raw button pins
btn_level  output  N_BTN  debounced, registered button level
btn_pulse  output  N_BTN  one-cycle pulse on each accepted press (and each repeat)
btn_release  output  N_BTN  one-cycle pulse on each accepted release

Behaviour:
- Reset: when RST is high at a CLK edge, clear both synchroniser stages, stable state, all counters, btn_level, btn_pulse and btn_release to 0. A reset mid-debounce discards all progress.
- Synchroniser: 2-FF chain per bit (s1 <= btn_raw, s2 <= s1). Only s2 is used downstream.
- Debounce per bit, with counter cnt of width $clog2(DEBOUNCE_CYCLES+1):
  - s2 == btn_level: cnt <= 0.
  - s2 != btn_level and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - s2 != btn_level and cnt == DEBOUNCE_CYCLES-1: btn_level <= s2 and cnt <= 0. Assert btn_pulse for one cycle if s2 == 1, else btn_release.
  - Any bounce back to equality before the terminal count restarts the count from 0.
- Latency: btn_raw stable high from edge k gives btn_level = 1 and btn_pulse = 1 after edge k+1+DEBOUNCE_CYCLES. btn_pulse is registered and is high in the same cycle that btn_level first reads 1. Release is symmetric.
- btn_pulse and btn_release are never both high on the same bit, and each is never high for 2 consecutive cycles without BTN_AUTOREPEAT_EN.
- Simultaneous presses on different bits are independent; pulses may coincide. Arbitration is the menu's job.
- A button held through reset deassertion is re-debounced from 0 and produces one btn_pulse DEBOUNCE_CYCLES+2 cycles after RST falls.
- Minimal config DEBOUNCE_CYCLES = 1: accept on the first cycle of s2 mismatch.

Optional Feature:
Macro BTN_AUTOREPEAT_EN.
- Defined: each bit has a hold counter that is cleared on every btn_pulse and on btn_level = 0.
  - While btn_level stays 1, an extra one-cycle btn_pulse fires HOLD_CYCLES cycles after the press pulse.
  - Further pulses then fire every REPEAT_CYCLES cycles until release.
  - btn_release behaviour is unchanged. Reset clears the hold counters.
- Undefined: no hold counters are synthesised; exactly one btn_pulse per accepted press.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3.
- Reset: RST high 3 cycles with btn_raw=5'b11111 -> all outputs 0 during reset; btn_pulse=5'b11111 exactly once, 6 cycles after RST falls.
- Clean press: btn_raw[2] 0->1 at edge k, held 20 cycles -> btn_level[2] and btn_pulse[2] high after edge k+5; pulse lasts 1 cycle; other bits stay 0.
- Bounce: btn_raw[3] toggles 1,0,1,0 each cycle and then holds 1 -> no pulse during the toggling; a single pulse 5 cycles after the final stable edge.
- Release: after a press, btn_raw[3] goes 1->0 -> btn_release[3] for 1 cycle after 5 cycles, btn_level[3]=0, and btn_pulse stays 0.
- Simultaneous events: btn_raw[1] and btn_raw[4] rise on the same edge while RST is asserted mid-debounce on cycle 3 -> no outputs; after reset both bits pulse together.
- With BTN_AUTOREPEAT_EN, hold btn_raw[0] for 30 cycles past acceptance -> pulses at acceptance, then at +10, +13, +16 ... (+10, +13, +16, +19, +22, +25, +28); none after release. Without the macro -> exactly 1 pulse.
